// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline stage with a multi-cycle data memory.
// Optional misaligned-access trap enabled by defining MISALIGN_TRAP_EN.
module mem_wb_stage #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        WB_i,
    input  logic [1:0]  Mem_i,
    input  logic [31:0] Memaddr_i,
    input  logic [31:0] Memdata_i,
    input  logic [31:0] ALUres_i,
    input  logic [4:0]  rd_addr_i,
    output logic        stall_o,
    output logic        WB_o,
    output logic [4:0]  rd_addr_o,
`ifdef MISALIGN_TRAP_EN
    output logic [31:0] wb_data_o,
    output logic        misalign_o
`else
    output logic [31:0] wb_data_o
`endif
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            load_q;
    logic [AW-1:0]   idx_q;
    logic [31:0]     data_q;
    logic [4:0]      rd_q;
    logic            wb_q;

    logic [31:0]     mem [DEPTH_WORDS];

    logic [AW-1:0]   idx;
    logic            is_mem;
    logic            misal;
    logic            accept;
    logic            done;
    logic            unused_addr;

    assign idx    = Memaddr_i[AW+1:2];
    assign is_mem = (Mem_i == 2'b01) || (Mem_i == 2'b10);

`ifdef MISALIGN_TRAP_EN
    assign misal  = |Memaddr_i[1:0];
`else
    assign misal  = 1'b0;
`endif

    assign accept = (state == IDLE) && is_mem && !misal;
    assign done   = (state == BUSY) && (cnt == '0);

    // Upper address bits alias; low bits only matter for the trap
    assign unused_addr = ^{Memaddr_i[31:AW+2], Memaddr_i[1:0]};

    // Hold upstream while an access is being accepted or counting down
    always_comb begin
        stall_o = 1'b0;
        if (rst_i) begin
            stall_o = accept || ((state == BUSY) && (cnt != '0));
        end
    end

    // Commit the latched store on the final busy edge; array is never reset
    always_ff @(posedge clk_i) begin
        if (rst_i && done && !load_q) begin
            mem[idx_q] <= data_q;
        end
    end

    // Access FSM plus MEM/WB result register
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state     <= IDLE;
            cnt       <= '0;
            load_q    <= 1'b0;
            idx_q     <= '0;
            data_q    <= '0;
            rd_q      <= '0;
            wb_q      <= 1'b0;
            WB_o      <= 1'b0;
            rd_addr_o <= '0;
            wb_data_o <= '0;
`ifdef MISALIGN_TRAP_EN
            misalign_o <= 1'b0;
`endif
        end else begin
`ifdef MISALIGN_TRAP_EN
            misalign_o <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (accept) begin
                        load_q <= Mem_i[1];
                        idx_q  <= idx;
                        data_q <= Memdata_i;
                        rd_q   <= rd_addr_i;
                        wb_q   <= WB_i;
                        cnt    <= CW'(LATENCY - 1);
                        state  <= BUSY;
                        WB_o   <= 1'b0;
`ifdef MISALIGN_TRAP_EN
                    end else if (is_mem && misal) begin
                        misalign_o <= 1'b1;
                        WB_o       <= 1'b0;
                        rd_addr_o  <= rd_addr_i;
                        wb_data_o  <= Memaddr_i;
`endif
                    end else begin
                        WB_o      <= WB_i;
                        rd_addr_o <= rd_addr_i;
                        wb_data_o <= ALUres_i;
                    end
                end
                BUSY: begin
                    WB_o <= 1'b0;
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state     <= IDLE;
                        rd_addr_o <= rd_q;
                        if (load_q) begin
                            wb_data_o <= mem[idx_q];
                            WB_o      <= wb_q;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    WB_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed plus randomized check of mem_wb_stage
// against a transaction-level reference model.
module tb_mem_wb_stage;

    localparam int DEPTH = 256;
    localparam int LAT   = 2;
    localparam int AW    = $clog2(DEPTH);

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wb_i = 1'b0;
    logic [1:0]  mem_i = 2'b00;
    logic [31:0] addr_i = '0;
    logic [31:0] data_i = '0;
    logic [31:0] alu_i = '0;
    logic [4:0]  rd_i = '0;
    logic        stall;
    logic        wb_o;
    logic [4:0]  rd_o;
    logic [31:0] wbd_o;
`ifdef MISALIGN_TRAP_EN
    logic        mis_o;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] ref_mem [DEPTH];
    logic [31:0] ref_wbd = '0;

    mem_wb_stage #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .WB_i      (wb_i),
        .Mem_i     (mem_i),
        .Memaddr_i (addr_i),
        .Memdata_i (data_i),
        .ALUres_i  (alu_i),
        .rd_addr_i (rd_i),
        .stall_o   (stall),
        .WB_o      (wb_o),
        .rd_addr_o (rd_o),
`ifdef MISALIGN_TRAP_EN
        .wb_data_o (wbd_o),
        .misalign_o(mis_o)
`else
        .wb_data_o (wbd_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one instruction at a negedge; return at the negedge where
    // its result is visible, after checking it.
    task automatic do_op(input logic [1:0] op, input logic we,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [31:0] alu, input logic [4:0] rd);
        int          n;
        bit          memop;
        bit          trap;
        logic [31:0] exp_d;
        logic        exp_wb;
        logic [AW-1:0] ix;
        mem_i  = op;
        wb_i   = we;
        addr_i = addr;
        data_i = data;
        alu_i  = alu;
        rd_i   = rd;
        memop  = (op == 2'b01) || (op == 2'b10);
        trap   = 1'b0;
`ifdef MISALIGN_TRAP_EN
        trap   = memop && (addr[1:0] != 2'b00);
`endif
        ix = addr[AW+1:2];
        #1;
        n = 0;
        while (stall === 1'b1 && n < 20) begin
            if (n > 0) check("wb_bubble", wb_o, 1'b0);
            n++;
            @(negedge clk);
            #1;
        end
        if (n > 0) check("wb_bubble_last", wb_o, 1'b0);
        check("stall_cycles", n, (memop && !trap) ? LAT : 0);
        if (trap) begin
            exp_wb  = 1'b0;
            ref_wbd = addr;
        end else if (op == 2'b01) begin
            ref_mem[ix] = data;
            exp_wb = 1'b0;
        end else if (op == 2'b10) begin
            exp_wb  = we;
            ref_wbd = ref_mem[ix];
        end else begin
            exp_wb  = we;
            ref_wbd = alu;
        end
        exp_d = ref_wbd;
        @(negedge clk);
        check("wb_o", wb_o, exp_wb);
        check("rd_addr_o", rd_o, rd);
        check("wb_data_o", wbd_o, exp_d);
`ifdef MISALIGN_TRAP_EN
        check("misalign_o", mis_o, trap);
`endif
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check("rst_stall", stall, 1'b0);
        check("rst_wb", wb_o, 1'b0);
        check("rst_rd", rd_o, 5'd0);
        check("rst_data", wbd_o, 32'h0);
`ifdef MISALIGN_TRAP_EN
        check("rst_mis", mis_o, 1'b0);
`endif
        rst = 1'b1;

        do_op(2'b00, 1'b1, 32'h0, 32'h0, 32'h1234, 5'd5);
        do_op(2'b01, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 5'd3);
        do_op(2'b10, 1'b1, 32'h10, 32'h0, 32'h0, 5'd7);
        check("load_dead", wbd_o, 32'hDEADBEEF);
        do_op(2'b01, 1'b0, 32'h400, 32'h1, 32'h0, 5'd0);
        do_op(2'b10, 1'b1, 32'h0, 32'h0, 32'h0, 5'd9);
        check("alias", wbd_o, 32'h1);
        do_op(2'b11, 1'b1, 32'h0, 32'h0, 32'h55, 5'd4);
        check("reserved_pass", wbd_o, 32'h55);
        do_op(2'b10, 1'b1, 32'h13, 32'h0, 32'h0, 5'd6);

        // Abort a store with reset on its second stall cycle
        do_op(2'b01, 1'b0, 32'h20, 32'hA5, 32'h0, 5'd1);
        mem_i  = 2'b01;
        addr_i = 32'h20;
        data_i = 32'h7777_7777;
        #1;
        check("abort_stall1", stall, 1'b1);
        @(negedge clk);
        #1;
        check("abort_stall2", stall, 1'b1);
        rst = 1'b0;
        #1;
        check("abort_stall_rst", stall, 1'b0);
        @(negedge clk);
        check("abort_wb", wb_o, 1'b0);
        check("abort_rd", rd_o, 5'd0);
        check("abort_data", wbd_o, 32'h0);
        ref_wbd = '0;
        rst = 1'b1;
        do_op(2'b00, 1'b1, 32'h0, 32'h0, 32'hCAFE, 5'd2);
        do_op(2'b10, 1'b1, 32'h20, 32'h0, 32'h0, 5'd8);
        check("abort_nowrite", wbd_o, 32'hA5);

        // Randomized traffic over 16 aliased words
        for (int i = 0; i < 16; i++) begin
            do_op(2'b01, 1'b0, 32'(i) << 2, $urandom, 32'h0, 5'(i));
        end
        for (int i = 0; i < 80; i++) begin
            logic [31:0] a;
            a = ($urandom & 32'hFFFF_FC00) | (($urandom % 16) << 2)
                | ($urandom % 4);
            do_op(2'($urandom % 4), 1'($urandom), a, $urandom,
                  $urandom, 5'($urandom));
        end
        mem_i = 2'b00;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Consumer end of the EX/MEM interface: accepts memory-stage control and data, performs the data-memory access, and registers results toward writeback (MEM/WB register).
- Holds a word-addressed data memory with a fixed multi-cycle access latency.
- Back-pressures the upstream pipeline with stall_o while an access is in flight.
- Sits between the EX/MEM boundary and the register-file write port.

Parameters:
- DEPTH_WORDS, 256: number of 32-bit words in the data memory; power of two, ≥4.
- LATENCY, 2: stall cycles per load/store, ≥1.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-low.
- WB_i  in  1  register-write enable of the incoming instruction.
- Mem_i  in  2  memory op: 00 none, 01 store, 10 load, 11 reserved (treated as none).
- Memaddr_i  in  32  byte address.
- Memdata_i  in  32  store data.
- ALUres_i  in  32  ALU result for non-load writeback.
- rd_addr_i  in  5  destination register.
- stall_o  out  1  upstream must hold all inputs stable and not advance.
- WB_o  out  1  registered register-write enable.
- rd_addr_o  out  5  registered destination register.
- wb_data_o  out  32  registered writeback data.

Behaviour:
- **Reset.** Applies while rst_i=0 at a clock edge:
  - state=IDLE, cnt=0, WB_o=0, rd_addr_o=0, wb_data_o=0.
  - The memory array is not cleared.
  - stall_o=0 while in reset.
- **Word index.** idx = Memaddr_i[log2(DEPTH_WORDS)+1:2]. Higher address bits are ignored, so the array aliases modulo DEPTH_WORDS. Bits [1:0] are ignored.
- **FSM: IDLE, BUSY.**
- **IDLE, Mem_i ∈ {00, 11}.**
  - stall_o=0.
  - Next edge: WB_o←WB_i, rd_addr_o←rd_addr_i, wb_data_o←ALUres_i. Latency 1.
- **IDLE, Mem_i ∈ {01, 10}.**
  - stall_o=1 combinationally in the same cycle (T).
  - Latch op, index, Memdata_i, rd_addr_i, WB_i.
  - cnt←LATENCY-1; go to BUSY.
  - WB_o←0 (bubble).
- **BUSY, cnt≠0.**
  - stall_o=1; cnt←cnt-1; WB_o←0.
- **BUSY, cnt=0.**
  - stall_o=0. The access commits at this edge; state→IDLE.
  - Store: mem[idx]←latched data; WB_o←0; wb_data_o unchanged; rd_addr_o←latched rd.
  - Load: wb_data_o←mem[idx] (old contents); WB_o←latched WB; rd_addr_o←latched rd.
- **Timing.** stall_o is high for cycles T..T+LATENCY-1. Completion happens at the edge ending cycle T+LATENCY. Results are visible in cycle T+LATENCY+1. Upstream advances on that same edge, so the op is accepted exactly once.
- **Operands in BUSY.** Inputs during BUSY are ignored; latched copies are used.
- **Back-to-back ops.** A load immediately after a store to the same index returns the stored value. The store commits before the load's accept, because each op spends ≥2 cycles in the FSM.
- **Reset mid-operation.** Aborts: no memory write, no WB pulse, FSM→IDLE.
- **Unused state encodings.** Recover to IDLE.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- **Defined:**
  - Adds output port misalign_o (1 bit, reset 0).
  - In IDLE, a load or store with Memaddr_i[1:0]≠0 is not performed and stall_o stays 0.
  - Next edge: misalign_o←1 for exactly one cycle, WB_o←0, rd_addr_o←rd_addr_i, wb_data_o←Memaddr_i. No memory write.
  - misalign_o←0 on every other edge.
- **Undefined:** no misalign_o port; address bits [1:0] are ignored as above.

Test Plan:
- Reset, then Mem=00, WB=1, rd=5, ALUres=0x1234 for 1 cycle → next cycle WB_o=1, rd_addr_o=5, wb_data_o=0x1234, stall_o never 1.
- LATENCY=2: store addr 0x10, data 0xDEADBEEF, held while stalled → stall_o=1 for exactly 2 cycles, WB_o=0 throughout. Then load addr 0x10, rd=7 → WB_o=1, rd_addr_o=7, wb_data_o=0xDEADBEEF 3 cycles after the load is presented.
- Aliasing, DEPTH_WORDS=256: store 0x1 to addr 0x400, load addr 0x0 → wb_data_o=0x1.
- rst_i=0 on the second stall cycle of a store to addr 0x20 (previously loaded as 0xA5) → stall_o=0 and FSM IDLE after the edge. A later load of 0x20 returns 0xA5, not the aborted data.
- Mem=11, WB=1, ALUres=0x55 → treated as passthrough: no stall, wb_data_o=0x55 next cycle.
- With MISALIGN_TRAP_EN: load addr 0x13 → stall_o=0, misalign_o=1 for one cycle, WB_o=0, wb_data_o=0x13. Without the macro: the same load reads the word at idx 4.
